sudoku_board_dumper: RTL and testbench
======================================

Name: sudoku_board_dumper

Overview:
- Upstream feeder for the UART transmitter.
- On request, snapshots the 9x9 Sudoku board and streams it as 99 ASCII bytes: 9 rows of 9 characters plus CR LF.
- Paces bytes using the transmitter's start/busy handshake.
- Sits between the game core (board register file) and the UART TX block.

Parameters:
- CELL_W, 4, bits per cell in the flattened board input.
- EMPTY_CHAR, 8'h2E, ASCII byte sent for a cell value of 0 ('.').
- BAD_CHAR, 8'h3F, ASCII byte sent for a cell value greater than 9 ('?').

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- board_flat  input  81*CELL_W  board contents; cell (r,c) at bits [(r*9+c)*CELL_W +: CELL_W].
- dump_req  input  1  single-cycle request to transmit the board.
- tx_busy  input  1  busy flag from the UART transmitter.
- tx_data  output  8  byte presented to the transmitter.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- dump_busy  output  1  high while a dump is in progress.
- dump_done  output  1  one-cycle pulse after the final byte completes.

Behaviour:
- Reset values: tx_data=8'h00, tx_start=0, dump_busy=0, dump_done=0, state=IDLE, row=0, col=0, snapshot cleared. All outputs are registered.
- States: IDLE, SEND, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE:
  - dump_req=1 latches board_flat into an internal snapshot.
  - Sets row=0, col=0, dump_busy<=1, next state SEND.
  - Later changes to board_flat do not affect the dump in progress (no tearing).
- SEND:
  - tx_data is driven from the current (row,col) position.
  - If tx_busy=0: tx_start<=1, next state WAIT_ACK.
  - If tx_busy=1: stay in SEND with tx_start=0 (waits out a foreign or previous byte).
- WAIT_ACK:
  - tx_start<=0, so the pulse is exactly one cycle wide.
  - Stay until tx_busy=1, then go to WAIT_DONE.
  - The transmitter raises busy one cycle after sampling start, so at least one wait cycle always occurs here.
- WAIT_DONE:
  - Stay until tx_busy=0.
  - Then advance the position:
    - col 0..9 -> col+1.
    - col 10 and row<8 -> col=0, row+1, back to SEND.
    - col 10 and row=8 -> FINISH.
- FINISH: dump_done<=1 for one cycle, dump_busy<=0, next state IDLE.
- Byte mapping:
  - col 0..8: cell value v=0 -> EMPTY_CHAR; v=1..9 -> 8'h30+v; v>9 -> BAD_CHAR.
  - col 9 -> 8'h0D. col 10 -> 8'h0A.
- tx_data holds stable from the SEND cycle through the end of WAIT_DONE.
- Total bytes per dump: 99. Exactly 99 tx_start pulses per dump.
- dump_req while dump_busy=1 is ignored (not queued).
- dump_req in the FINISH cycle is ignored. A request is accepted only in IDLE.
- Reset mid-dump: the FSM returns to IDLE immediately with reset values. No dump_done pulse is generated. The transmitter shares rst and aborts too.
- No timeout: if tx_busy never rises after a start, the block waits indefinitely in WAIT_ACK. This is the documented limitation.
- Counter widths: row 4 bits (0..8), col 4 bits (0..10). No wrap beyond these limits.

Test Plan:
- Board all zeros, dump_req pulse, behavioural UART (BAUD_DIV=4) -> 99 bytes captured, each row "........." then 0D 0A; dump_done exactly once; dump_busy low afterwards.
- Board row r, col c = ((r*3+r/3+c)%9)+1 (a valid solution) -> first line "123456789", second "456789123", last "912345678", each followed by 0D 0A.
- Cell (4,4)=4'hC, cell (0,0)=0 -> byte 0 is 8'h2E; byte index 4*11+4=48 is 8'h3F.
- Change board_flat and pulse dump_req again mid-dump, at byte 20 -> output matches the original snapshot; still 99 bytes; one dump_done.
- Hold tx_busy=1 externally for 50 cycles when the dump starts -> no tx_start until tx_busy falls, then the first pulse is one cycle wide with tx_data=first character.
- Assert rst during byte 30 -> all outputs go to reset values in the same cycle; no dump_done; a new dump_req afterwards yields a full, correct 99-byte dump.

Source files
------------

// File: rtl/sudoku_board_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : sudoku_board_dumper
//  Purpose  : Snapshots the 9x9 Sudoku board on request and streams it to the
//             UART transmitter as 99 ASCII bytes (9 rows of 9 characters,
//             each row followed by CR LF), pacing every byte with the
//             transmitter's start/busy handshake.
//  Ports    : clk        - system clock
//             rst        - asynchronous, active-high reset
//             board_flat - board contents, cell (r,c) at [(r*9+c)*CELL_W +: CELL_W]
//             dump_req   - single-cycle request to transmit the board
//             tx_busy    - busy flag from the UART transmitter
//             tx_data    - byte presented to the transmitter (registered)
//             tx_start   - one-cycle start pulse to the transmitter (registered)
//             dump_busy  - high while a dump is in progress (registered)
//             dump_done  - one-cycle pulse after the final byte (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module sudoku_board_dumper #(
    parameter int          CELL_W     = 4,
    parameter logic [7:0]  EMPTY_CHAR = 8'h2E,
    parameter logic [7:0]  BAD_CHAR   = 8'h3F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [81*CELL_W-1:0]  board_flat,
    input  logic                  dump_req,
    input  logic                  tx_busy,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    output logic                  dump_busy,
    output logic                  dump_done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    localparam logic [3:0]        c_cr_col   = 4'd9;
    localparam logic [3:0]        c_last_col = 4'd10;
    localparam logic [3:0]        c_last_row = 4'd8;
    localparam logic [CELL_W-1:0] c_nine     = CELL_W'(9);

    state_t              r_state;
    state_t              w_state_nx;
    logic [3:0]          r_row;
    logic [3:0]          r_col;
    logic [3:0]          w_row_nx;
    logic [3:0]          w_col_nx;
    logic [7:0]          w_data_nx;
    logic                w_start_nx;
    logic                w_busy_nx;
    logic                w_done_nx;
    logic                w_snap_load;
    logic [CELL_W-1:0]   r_snap [0:80];
    logic [6:0]          w_idx;
    logic [CELL_W-1:0]   w_cell;
    logic [7:0]          w_char;

    // Private copy of the board so a dump in flight never tears when the
    // game core updates cells.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 81; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_snap_load) begin
            for (int i = 0; i < 81; i++) begin
                r_snap[i] <= board_flat[i*CELL_W +: CELL_W];
            end
        end
    end

    // CR/LF columns have no cell behind them; point at cell 0 to keep the
    // index inside the array.
    assign w_idx  = (r_col < c_cr_col) ? ({3'b000, r_row} * 7'd9 + {3'b000, r_col}) : 7'd0;
    assign w_cell = r_snap[w_idx];

    always_comb begin
        w_char = 8'h00;
        if (r_col == c_cr_col) begin
            w_char = 8'h0D;
        end else if (r_col == c_last_col) begin
            w_char = 8'h0A;
        end else if (w_cell == '0) begin
            w_char = EMPTY_CHAR;
        end else if (w_cell > c_nine) begin
            w_char = BAD_CHAR;
        end else begin
            w_char = 8'h30 + 8'(w_cell);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_row_nx    = r_row;
        w_col_nx    = r_col;
        w_data_nx   = tx_data;
        w_start_nx  = 1'b0;
        w_busy_nx   = dump_busy;
        w_done_nx   = 1'b0;
        w_snap_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dump_req) begin
                    w_snap_load = 1'b1;
                    w_row_nx    = 4'd0;
                    w_col_nx    = 4'd0;
                    w_busy_nx   = 1'b1;
                    w_state_nx  = S_SEND;
                end
            end
            S_SEND: begin
                // Data is reloaded every SEND cycle; position is frozen here,
                // so the byte is settled by the time start is seen.
                w_data_nx = w_char;
                if (!tx_busy) begin
                    w_start_nx = 1'b1;
                    w_state_nx = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    w_state_nx = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (r_col != c_last_col) begin
                        w_col_nx   = r_col + 4'd1;
                        w_state_nx = S_SEND;
                    end else if (r_row != c_last_row) begin
                        w_col_nx   = 4'd0;
                        w_row_nx   = r_row + 4'd1;
                        w_state_nx = S_SEND;
                    end else begin
                        w_state_nx = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_row     <= 4'd0;
            r_col     <= 4'd0;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            dump_busy <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_row     <= w_row_nx;
            r_col     <= w_col_nx;
            tx_data   <= w_data_nx;
            tx_start  <= w_start_nx;
            dump_busy <= w_busy_nx;
            dump_done <= w_done_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sudoku_board_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sudoku_board_dumper
//  Purpose  : Self-checking bench for sudoku_board_dumper with a behavioural
//             UART transmitter and a byte-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sudoku_board_dumper;

    localparam int CELL_W   = 4;
    localparam int BW       = 81 * CELL_W;
    localparam int BAUD_DIV = 4;
    localparam int FRAME    = 10 * BAUD_DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] board_flat = '0;
    logic          dump_req = 1'b0;
    logic          tx_busy;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          dump_busy;
    logic          dump_done;

    logic          uart_busy;
    logic          ext_busy = 1'b0;
    int            uart_cnt;
    logic [7:0]    cap_q [$];
    int            start_cnt = 0;
    int            wide_cnt  = 0;
    int            done_cnt  = 0;
    logic          prev_start = 1'b0;
    int            check_cnt = 0;
    int            fail_cnt  = 0;

    assign tx_busy = uart_busy | ext_busy;

    always #5 clk = ~clk;

    sudoku_board_dumper #(
        .CELL_W     (CELL_W),
        .EMPTY_CHAR (8'h2E),
        .BAD_CHAR   (8'h3F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .board_flat (board_flat),
        .dump_req   (dump_req),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    // Behavioural transmitter: samples start while idle, busy visible from
    // the next cycle, held for one 10-bit frame.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_busy <= 1'b0;
            uart_cnt  <= 0;
        end else if (!uart_busy) begin
            if (tx_start) begin
                uart_busy <= 1'b1;
                uart_cnt  <= FRAME;
                cap_q.push_back(tx_data);
            end
        end else if (uart_cnt == 1) begin
            uart_busy <= 1'b0;
            uart_cnt  <= 0;
        end else begin
            uart_cnt <= uart_cnt - 1;
        end
    end

    always @(posedge clk) begin
        prev_start <= tx_start;
        if (tx_start)               start_cnt <= start_cnt + 1;
        if (tx_start && prev_start) wide_cnt  <= wide_cnt + 1;
        if (dump_done)              done_cnt  <= done_cnt + 1;
    end

    // Reference: byte k of a dump is row k/11, column k%11.
    function automatic logic [7:0] exp_byte(input logic [BW-1:0] b, input int k);
        int r;
        int c;
        int v;
        r = k / 11;
        c = k % 11;
        if (c == 9)  return 8'h0D;
        if (c == 10) return 8'h0A;
        v = int'(b[(r*9+c)*CELL_W +: CELL_W]);
        if (v == 0) return 8'h2E;
        if (v > 9)  return 8'h3F;
        return 8'(48 + v);
    endfunction

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        for (int i = 0; i < 81; i++) b[i*CELL_W +: CELL_W] = CELL_W'($urandom_range(0, 15));
        return b;
    endfunction

    task automatic start_dump(input logic [BW-1:0] b);
        @(negedge clk);
        board_flat = b;
        dump_req   = 1'b1;
        @(negedge clk);
        dump_req   = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (dump_done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_bytes(input int base, input int cnt, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (cap_q.size() - base >= cnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        check_cnt++;
        if ({tx_data, tx_start, dump_busy, dump_done} !== 11'd0) begin
            fail_cnt++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b, required 00/0/0/0", tx_data, tx_start, dump_busy, dump_done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_cnt++;
        if ({tx_data, tx_start, dump_busy, dump_done} !== 11'd0) begin
            fail_cnt++;
            $display("FAIL idle_outputs: got %h/%b/%b/%b, required 00/0/0/0", tx_data, tx_start, dump_busy, dump_done);
        end
    endtask

    task automatic test_zero_board();
        logic [BW-1:0] b = '0;
        int  base = cap_q.size();
        int  d0 = done_cnt, s0 = start_cnt, w0 = wide_cnt;
        bit  ok;
        start_dump(b);
        check_cnt++;
        if (dump_busy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL zero_busy_high: got %b, required 1", dump_busy);
        end
        wait_done(ok);
        check_cnt++;
        if (!ok) begin fail_cnt++; $display("FAIL zero_timeout: got no dump_done, required one"); end
        check_cnt++;
        if (cap_q.size() - base != 99) begin
            fail_cnt++;
            $display("FAIL zero_count: got %0d bytes, required 99", cap_q.size() - base);
        end
        for (int k = 0; k < 99 && base + k < cap_q.size(); k++) begin
            check_cnt++;
            if (cap_q[base+k] !== exp_byte(b, k)) begin
                fail_cnt++;
                $display("FAIL zero_byte[%0d]: got %h, required %h", k, cap_q[base+k], exp_byte(b, k));
            end
        end
        check_cnt++;
        if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL zero_done_count: got %0d, required 1", done_cnt - d0); end
        check_cnt++;
        if (start_cnt - s0 != 99) begin fail_cnt++; $display("FAIL zero_start_count: got %0d, required 99", start_cnt - s0); end
        check_cnt++;
        if (wide_cnt != w0) begin fail_cnt++; $display("FAIL zero_pulse_width: got %0d wide pulses, required 0", wide_cnt - w0); end
        check_cnt++;
        if (dump_busy !== 1'b0) begin fail_cnt++; $display("FAIL zero_busy_low: got %b, required 0", dump_busy); end
    endtask

    task automatic test_solution();
        logic [BW-1:0] b;
        int  base = cap_q.size();
        bit  ok;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                b[(r*9+c)*CELL_W +: CELL_W] = CELL_W'(((r*3 + r/3 + c) % 9) + 1);
        start_dump(b);
        wait_done(ok);
        check_cnt++;
        if (!ok || cap_q.size() - base != 99) begin
            fail_cnt++;
            $display("FAIL sol_count: got %0d bytes (done=%0b), required 99", cap_q.size() - base, ok);
        end
        for (int k = 0; k < 99 && base + k < cap_q.size(); k++) begin
            check_cnt++;
            if (cap_q[base+k] !== exp_byte(b, k)) begin
                fail_cnt++;
                $display("FAIL sol_byte[%0d]: got %h, required %h", k, cap_q[base+k], exp_byte(b, k));
            end
        end
        check_cnt++;
        if (cap_q.size() - base >= 99 &&
            {cap_q[base+0], cap_q[base+11], cap_q[base+88], cap_q[base+96]} !== {8'h31, 8'h34, 8'h39, 8'h38}) begin
            fail_cnt++;
            $display("FAIL sol_line_starts: got %h %h %h %h, required 31 34 39 38",
                     cap_q[base+0], cap_q[base+11], cap_q[base+88], cap_q[base+96]);
        end
    endtask

    task automatic test_bad_cell();
        logic [BW-1:0] b = rand_board();
        int  base = cap_q.size();
        bit  ok;
        b[0 +: CELL_W]             = '0;
        b[(4*9+4)*CELL_W +: CELL_W] = 4'hC;
        start_dump(b);
        wait_done(ok);
        check_cnt++;
        if (!ok || cap_q.size() - base != 99) begin
            fail_cnt++;
            $display("FAIL bad_count: got %0d bytes (done=%0b), required 99", cap_q.size() - base, ok);
        end
        check_cnt++;
        if (cap_q.size() - base > 48 && (cap_q[base] !== 8'h2E || cap_q[base+48] !== 8'h3F)) begin
            fail_cnt++;
            $display("FAIL bad_special: got %h/%h, required 2e/3f", cap_q[base], cap_q[base+48]);
        end
        for (int k = 0; k < 99 && base + k < cap_q.size(); k++) begin
            check_cnt++;
            if (cap_q[base+k] !== exp_byte(b, k)) begin
                fail_cnt++;
                $display("FAIL bad_byte[%0d]: got %h, required %h", k, cap_q[base+k], exp_byte(b, k));
            end
        end
    endtask

    task automatic test_no_tear();
        logic [BW-1:0] a = rand_board();
        int  base = cap_q.size();
        int  d0 = done_cnt, s0 = start_cnt;
        bit  ok;
        start_dump(a);
        wait_bytes(base, 20, ok);
        check_cnt++;
        if (!ok) begin fail_cnt++; $display("FAIL tear_progress: got %0d bytes, required 20", cap_q.size() - base); end
        start_dump(rand_board());
        wait_done(ok);
        repeat (200) @(negedge clk);
        check_cnt++;
        if (cap_q.size() - base != 99 || start_cnt - s0 != 99) begin
            fail_cnt++;
            $display("FAIL tear_count: got %0d bytes %0d starts, required 99", cap_q.size() - base, start_cnt - s0);
        end
        check_cnt++;
        if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL tear_done_count: got %0d, required 1", done_cnt - d0); end
        for (int k = 0; k < 99 && base + k < cap_q.size(); k++) begin
            check_cnt++;
            if (cap_q[base+k] !== exp_byte(a, k)) begin
                fail_cnt++;
                $display("FAIL tear_byte[%0d]: got %h, required %h", k, cap_q[base+k], exp_byte(a, k));
            end
        end
    endtask

    task automatic test_busy_hold();
        logic [BW-1:0] b = rand_board();
        int  base = cap_q.size();
        int  s0 = start_cnt;
        bit  ok = 1'b0;
        ext_busy = 1'b1;
        start_dump(b);
        repeat (50) @(negedge clk);
        check_cnt++;
        if (start_cnt != s0) begin fail_cnt++; $display("FAIL hold_no_start: got %0d starts, required 0", start_cnt - s0); end
        ext_busy = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tx_start) begin ok = 1'b1; break; end
        end
        check_cnt++;
        if (!ok) begin fail_cnt++; $display("FAIL hold_start_seen: got no tx_start, required one"); end
        check_cnt++;
        if (tx_data !== exp_byte(b, 0)) begin
            fail_cnt++;
            $display("FAIL hold_first_data: got %h, required %h", tx_data, exp_byte(b, 0));
        end
        @(negedge clk);
        check_cnt++;
        if (tx_start !== 1'b0) begin fail_cnt++; $display("FAIL hold_pulse_width: got %b, required 0", tx_start); end
        wait_done(ok);
        check_cnt++;
        if (!ok || cap_q.size() - base != 99) begin
            fail_cnt++;
            $display("FAIL hold_count: got %0d bytes (done=%0b), required 99", cap_q.size() - base, ok);
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] b = rand_board();
        int  base = cap_q.size();
        int  d0 = done_cnt;
        bit  ok;
        start_dump(b);
        wait_bytes(base, 30, ok);
        rst = 1'b1;
        #1;
        check_cnt++;
        if ({tx_data, tx_start, dump_busy, dump_done} !== 11'd0) begin
            fail_cnt++;
            $display("FAIL rstmid_outputs: got %h/%b/%b/%b, required 00/0/0/0", tx_data, tx_start, dump_busy, dump_done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_cnt++;
        if (done_cnt != d0 || dump_busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL rstmid_no_done: got %0d done busy=%b, required 0 done busy=0", done_cnt - d0, dump_busy);
        end
        b    = rand_board();
        base = cap_q.size();
        start_dump(b);
        wait_done(ok);
        check_cnt++;
        if (!ok || cap_q.size() - base != 99) begin
            fail_cnt++;
            $display("FAIL rstmid_count: got %0d bytes (done=%0b), required 99", cap_q.size() - base, ok);
        end
        for (int k = 0; k < 99 && base + k < cap_q.size(); k++) begin
            check_cnt++;
            if (cap_q[base+k] !== exp_byte(b, k)) begin
                fail_cnt++;
                $display("FAIL rstmid_byte[%0d]: got %h, required %h", k, cap_q[base+k], exp_byte(b, k));
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_zero_board();
        test_solution();
        test_bad_cell();
        test_no_tear();
        test_busy_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
